// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute unit: opcode/funct3 constants,
// ALU operation enumeration (base ops, COPY_B and M-extension ops) and FSM states.
package exec_unit_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_COPY_B,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_ILLEGAL
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_HOLD} state_e;

  function automatic alu_op_e md_op_from_funct3(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'd0:    op = ALU_MUL;
      3'd1:    op = ALU_MULH;
      3'd2:    op = ALU_MULHSU;
      3'd3:    op = ALU_MULHU;
      3'd4:    op = ALU_DIV;
      3'd5:    op = ALU_DIVU;
      3'd6:    op = ALU_REM;
      default: op = ALU_REMU;
    endcase
    return op;
  endfunction

  function automatic logic is_md_op(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/exec_muldiv.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes,
// sign correction applied on the final step. start loads operands; done is
// high during the last iteration cycle with result valid alongside it.
module exec_muldiv
  import exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   count;
  alu_op_e         op_q;
  logic [XLEN-1:0] hi, lo, mag_b, a_q;
  logic            neg_q, neg_rem_q, b_zero_q;

  alu_op_e         op_in;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  logic [XLEN:0]   sum, rs, diff;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign done = busy && (count == CW'(XLEN - 1));

  // Operand conditioning at start: take magnitudes of the signed operands
  always_comb begin
    op_in    = md_op_from_funct3(funct3);
    sa       = (op_in inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && a[XLEN-1];
    sb       = (op_in inside {ALU_MULH, ALU_DIV, ALU_REM}) && b[XLEN-1];
    mag_a_in = sa ? -a : a;
    mag_b_in = sb ? -b : b;
  end

  // One iteration: shift-add multiply or restoring divide step
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    rs   = {hi, lo[XLEN-1]};
    diff = rs - {1'b0, mag_b};
    if (is_div_op(op_q)) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rs[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
    end
  end

  // Result is formed from the last step's next-state so it is ready one cycle earlier
  always_comb begin
    prod = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    quo  = neg_q ? -lo_nxt : lo_nxt;
    rem  = neg_rem_q ? -hi_nxt : hi_nxt;
    case (op_q)
      ALU_MUL:                         result = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:               result = b_zero_q ? '1 : quo;
      default:                         result = b_zero_q ? a_q : rem;
    endcase
  end

  // Iteration state: load on start, step while busy, stop after XLEN steps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      count     <= '0;
      op_q      <= ALU_MUL;
      hi        <= '0;
      lo        <= '0;
      mag_b     <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else if (start) begin
      busy      <= 1'b1;
      count     <= '0;
      op_q      <= op_in;
      hi        <= '0;
      lo        <= mag_a_in;
      mag_b     <= mag_b_in;
      a_q       <= a;
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      b_zero_q  <= (b == '0);
    end else if (busy) begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      count <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute unit: RV32-style decode and single-cycle base ALU, with an
// iterative multiply/divide sub-unit and a valid/ready handshake on both sides.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned MD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            add_rshift_type,
  input  logic            md_sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned SW = $clog2(XLEN);

  state_e          state;
  alu_op_e         dec_op;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;
  logic            accept, md_start, md_done;
  logic [XLEN-1:0] md_result;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_md_op(dec_op);

  // Decode opcode/funct3/instr bits into an ALU operation
  always_comb begin
    dec_op = ALU_ILLEGAL;
    case (opcode)
      OPC_LUI: dec_op = ALU_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: dec_op = ALU_ADD;
      OPC_OP_IMM, OPC_OP: begin
        if (opcode == OPC_OP && md_sel) begin
          dec_op = (MD_EN != 0) ? md_op_from_funct3(funct3) : ALU_ILLEGAL;
        end else begin
          case (funct3)
            F3_ADD:  dec_op = (opcode == OPC_OP && add_rshift_type) ? ALU_SUB : ALU_ADD;
            F3_SLL:  dec_op = ALU_SLL;
            F3_SLT:  dec_op = ALU_SLT;
            F3_SLTU: dec_op = ALU_SLTU;
            F3_XOR:  dec_op = ALU_XOR;
            F3_SR:   dec_op = add_rshift_type ? ALU_SRA : ALU_SRL;
            F3_OR:   dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end
      end
      default: dec_op = ALU_ILLEGAL;
    endcase
  end

  // Single-cycle base ALU; M ops and illegal encodings produce zero here
  always_comb begin
    shamt = b[SW-1:0];
    case (dec_op)
      ALU_ADD:    alu_res = a + b;
      ALU_SUB:    alu_res = a - b;
      ALU_SLL:    alu_res = a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:    alu_res = a ^ b;
      ALU_SRL:    alu_res = a >> shamt;
      ALU_SRA:    alu_res = $signed(a) >>> shamt;
      ALU_OR:     alu_res = a | b;
      ALU_AND:    alu_res = a & b;
      ALU_COPY_B: alu_res = b;
      default:    alu_res = '0;
    endcase
  end

  exec_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  // Control FSM with registered result, illegal flag and out_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_md_op(dec_op)) begin
              state     <= is_div_op(dec_op) ? ST_DIV : ST_MUL;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              illegal   <= (dec_op == ALU_ILLEGAL);
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            result    <= md_result;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed vector table, multi-cycle handshake and
// reset sequences, and randomized ops checked against an arithmetic model.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic        add_rshift_type, md_sel;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_illegal;
  logic [31:0] n_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_unit #(.XLEN(32), .MD_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .add_rshift_type(add_rshift_type), .md_sel(md_sel),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  exec_unit #(.XLEN(32), .MD_EN(0)) dut_nomd (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .opcode(opcode), .funct3(funct3), .add_rshift_type(add_rshift_type), .md_sel(md_sel),
    .a(a), .b(b), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .illegal(n_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model computed directly from the ISA arithmetic rules
  function automatic void ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic rt, input logic md,
                                    input logic [31:0] va, input logic [31:0] vb,
                                    input bit md_en, output logic [31:0] r,
                                    output logic il, output int lat);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [4:0]      sh;
    logic            ovf;
    sa  = $signed(va);
    sb  = $signed(vb);
    ua  = {32'd0, va};
    ub  = {32'd0, vb};
    sh  = vb[4:0];
    ovf = (va == 32'h8000_0000) && (vb == 32'hFFFF_FFFF);
    r = '0; il = 1'b0; lat = 1;
    if (opc == OPC_LUI) r = vb;
    else if (opc inside {OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE})
      r = va + vb;
    else if (opc == OPC_OP_IMM || (opc == OPC_OP && !md)) begin
      case (f3)
        3'd0: r = (opc == OPC_OP && rt) ? va - vb : va + vb;
        3'd1: r = va << sh;
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: r = va ^ vb;
        3'd5: if (rt) r = $signed(va) >>> sh; else r = va >> sh;
        3'd6: r = va | vb;
        default: r = va & vb;
      endcase
    end else if (opc == OPC_OP && md && md_en) begin
      lat = XLEN + 1;
      case (f3)
        3'd0: begin p = ua * ub; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
        3'd3: begin p = ua * ub; r = p[63:32]; end
        3'd4: r = (vb == 0) ? 32'hFFFF_FFFF : ovf ? va : 32'(sa / sb);
        3'd5: r = (vb == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
        3'd6: r = (vb == 0) ? va : ovf ? 32'd0 : 32'(sa % sb);
        default: r = (vb == 0) ? va : 32'(ua % ub);
      endcase
    end else begin
      il = 1'b1;
    end
  endfunction

  // Issue one op on the MD_EN=1 unit, measure latency, then retire it
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic rt,
                        input logic md, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] r, output logic il, output int lat,
                        output int rdy_busy);
    @(negedge clk);
    opcode = opc; funct3 = f3; add_rshift_type = rt; md_sel = md; a = va; b = vb;
    in_valid = 1'b1; out_ready = 1'b0;
    check1("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; rdy_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_busy++;
    end
    r = result; il = illegal;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        rt, md;
    logic [31:0] va, vb, res;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string n, input logic [6:0] opc, input logic [2:0] f3,
                                  input logic rt, input logic md, input logic [31:0] va,
                                  input logic [31:0] vb, input logic [31:0] res,
                                  input logic il, input int lat);
    vec_t v;
    v.name = n; v.opc = opc; v.f3 = f3; v.rt = rt; v.md = md;
    v.va = va; v.vb = vb; v.res = res; v.il = il; v.lat = lat;
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er;
    logic        il, eil;
    int          lat, elat, rdy;
    int          stale;
    logic [6:0]  ropc;
    logic [2:0]  rf3;
    logic        rrt, rmd;
    logic [31:0] ra, rb;

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    opcode = '0; funct3 = '0; add_rshift_type = 1'b0; md_sel = 1'b0; a = '0; b = '0;
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    check ("reset_result", result, 32'd0);
    check1("reset_illegal", illegal, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    add_vec("add",     OPC_OP,     3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    add_vec("sub",     OPC_OP,     3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    add_vec("addi_b30",OPC_OP_IMM, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    add_vec("sra",     OPC_OP,     3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
    add_vec("srl",     OPC_OP,     3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
    add_vec("srai",    OPC_OP_IMM, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 1'b0, 1);
    add_vec("slt",     OPC_OP,     3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    add_vec("sltu",    OPC_OP,     3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    add_vec("lui",     OPC_LUI,    3'd0, 1'b0, 1'b0, 32'h1234, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1);
    add_vec("store",   OPC_STORE,  3'd2, 1'b0, 1'b0, 32'h100, 32'h20, 32'h120, 1'b0, 1);
    add_vec("illegal", 7'h7F,      3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1, 1);
    add_vec("mulh",    OPC_OP,     3'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    add_vec("mulhu",   OPC_OP,     3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    add_vec("mul",     OPC_OP,     3'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd6, 32'hFFFF_FFEE, 1'b0, 33);
    add_vec("div_z",   OPC_OP,     3'd4, 1'b0, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    add_vec("rem_z",   OPC_OP,     3'd6, 1'b0, 1'b1, 32'd7, 32'd0, 32'd7, 1'b0, 33);
    add_vec("div_ovf", OPC_OP,     3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
    add_vec("rem_ovf", OPC_OP,     3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    add_vec("div_neg", OPC_OP,     3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    add_vec("rem_neg", OPC_OP,     3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);

    foreach (vecs[i]) begin
      run_op(vecs[i].opc, vecs[i].f3, vecs[i].rt, vecs[i].md, vecs[i].va, vecs[i].vb,
             r, il, lat, rdy);
      check ({vecs[i].name, "_result"}, r, vecs[i].res);
      check1({vecs[i].name, "_illegal"}, il, vecs[i].il);
      check ({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      if (vecs[i].lat > 1) check({vecs[i].name, "_in_ready_busy"}, rdy, 0);
    end

    // Result held while consumer stalls, then back-to-back base ops
    @(negedge clk);
    opcode = OPC_OP; funct3 = 3'd0; add_rshift_type = 1'b0; md_sel = 1'b0;
    a = 32'h11; b = 32'h22; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check ("hold_result", result, 32'h33);
      check1("hold_out_valid", out_valid, 1'b1);
      check1("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd1; b = 32'd100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("b2b_out_valid", out_valid, 1'b1);
      check ("b2b_result", result, 32'(i * 3 + 1) + 32'(100 + i));
      if (i < 9) begin
        a = 32'((i + 1) * 3 + 1); b = 32'(100 + i + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check1("b2b_drain", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset in the middle of a divide
    @(negedge clk);
    opcode = OPC_OP; funct3 = 3'd4; md_sel = 1'b1; a = 32'd100; b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check1("rst_mid_out_valid", out_valid, 1'b0);
    check1("rst_mid_in_ready", in_ready, 1'b1);
    check ("rst_mid_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_mid_no_stale", stale, 0);

    // First accept on the first rising edge after reset release
    reset = 1'b1;
    opcode = OPC_OP; funct3 = 3'd0; md_sel = 1'b0; add_rshift_type = 1'b0;
    a = 32'd5; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check1("post_rst_out_valid", out_valid, 1'b1);
    check ("post_rst_result", result, 32'd12);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // M encoding on a unit built without multiply/divide
    @(negedge clk);
    opcode = OPC_OP; funct3 = 3'd0; md_sel = 1'b1; a = 32'd3; b = 32'd4;
    n_in_valid = 1'b1; n_out_ready = 1'b0;
    check1("nomd_in_ready", n_in_ready, 1'b1);
    @(posedge clk);
    #1 n_in_valid = 1'b0;
    @(negedge clk);
    check1("nomd_out_valid", n_out_valid, 1'b1);
    check1("nomd_illegal", n_illegal, 1'b1);
    check ("nomd_result", n_result, 32'd0);
    n_out_ready = 1'b1;
    @(posedge clk);
    #1 n_out_ready = 1'b0;

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      rrt = 1'b0; rmd = 1'b0; rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 13))
        0:  ropc = OPC_LUI;
        1:  ropc = OPC_AUIPC;
        2:  ropc = OPC_JAL;
        3:  ropc = OPC_JALR;
        4:  ropc = OPC_BRANCH;
        5:  ropc = OPC_LOAD;
        6:  ropc = OPC_STORE;
        7, 8: begin ropc = OPC_OP_IMM; rrt = 1'($urandom_range(0, 1)); end
        9, 10: begin ropc = OPC_OP; rrt = 1'($urandom_range(0, 1)); end
        11, 12: begin ropc = OPC_OP; rmd = 1'b1; end
        default: ropc = 7'h0B;
      endcase
      ra = rand_operand();
      rb = rand_operand();
      ref_model(ropc, rf3, rrt, rmd, ra, rb, 1'b1, er, eil, elat);
      run_op(ropc, rf3, rrt, rmd, ra, rb, r, il, lat, rdy);
      check ("rand_result", r, er);
      check1("rand_illegal", il, eil);
      check ("rand_latency", lat, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
